// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_t;

    localparam int unsigned INC_RV32I  = 4;
    localparam int unsigned INC_RVC    = 2;
    localparam int unsigned ADDR_W_MAX = 64;

    // Clears the low log2(inc) bits; inc is a power of two (2 or 4).
    function automatic logic [ADDR_W_MAX-1:0] align_pc(
        input logic [ADDR_W_MAX-1:0] addr,
        input int unsigned           inc
    );
        logic [ADDR_W_MAX-1:0] mask;
        mask = ADDR_W_MAX'(inc - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC and pending-target selection for pc_unit.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned INC  = INC_RV32I
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pend_target,
    input  logic [XLEN-1:0] redirect_target_aligned,
    input  logic            pend_active,
    input  logic            redirect_taken,
    input  logic            fetch_fire,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pend_next,
    output logic [XLEN-1:0] pc_plus_inc
);

    assign pc_plus_inc = pc + XLEN'(INC);

    // A fresh redirect beats the stored one, which beats the sequential step.
    always_comb begin
        pc_next   = pc;
        pend_next = pend_target;
        if (redirect_taken) begin
            pend_next = redirect_target_aligned;
        end
        if (fetch_fire) begin
            if (redirect_taken) begin
                pc_next = redirect_target_aligned;
            end else if (pend_active) begin
                pc_next = pend_target;
            end else begin
                pc_next = pc_plus_inc;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with valid/ready handshake, stall and deferred redirect.
// Optional misaligned-redirect flag is built when PC_MISALIGN_CHECK_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      INC          = INC_RV32I
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            fetch_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            fetch_fire,
    output logic            kill_fetch,
    output pc_state_t       state_dbg
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            misalign_err
`endif
);

    // Handshake: a fetch is accepted in any cycle where pc_valid and fetch_ready
    // are high and stall is low; pc_out is held stable while pc_valid is high
    // and the fetch has not been accepted.

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] target_aligned;
    logic            accept_ok;
    logic            redirect_taken;

    assign target_aligned = XLEN'(align_pc(ADDR_W_MAX'(redirect_target), INC));
    assign accept_ok      = fetch_ready & ~stall;

    always_comb begin
        state_d        = state_q;
        pc_valid       = 1'b0;
        redirect_taken = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                pc_valid = 1'b1;
                if (redirect_valid) begin
                    redirect_taken = 1'b1;
                    if (!accept_ok) begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                pc_valid       = 1'b1;
                redirect_taken = redirect_valid;
                if (accept_ok) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        fetch_fire = pc_valid & accept_ok;
        // The address leaving this cycle is stale whenever a redirect is known.
        kill_fetch = fetch_fire & ((state_q == PEND) | redirect_taken);
    end

    pc_next_sel #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_next_sel (
        .pc                      (pc_q),
        .pend_target             (pend_q),
        .redirect_target_aligned (target_aligned),
        .pend_active             (state_q == PEND),
        .redirect_taken          (redirect_taken),
        .fetch_fire              (fetch_fire),
        .pc_next                 (pc_d),
        .pend_next               (pend_d),
        .pc_plus_inc             (pc_plus_inc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_out    = pc_q;
    assign state_dbg = state_q;

`ifdef PC_MISALIGN_CHECK_EN
    logic misaligned;

    assign misaligned = |(redirect_target & XLEN'(INC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_taken & misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic against a reference model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int unsigned INC  = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_ready;
  logic        pc_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        fetch_fire;
  logic        kill_fetch;
  pc_state_t   state_dbg;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INC          (INC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_ready     (fetch_ready),
    .pc_valid        (pc_valid),
    .pc_out          (pc_out),
    .pc_plus_inc     (pc_plus_inc),
    .fetch_fire      (fetch_fire),
    .kill_fetch      (kill_fetch),
    .state_dbg       (state_dbg)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: booted flag, current PC, optional pending target
  bit          m_booted;
  bit          m_pending;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_pend_tgt;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted   = 1'b0;
    m_pending  = 1'b0;
    m_mis      = 1'b0;
    m_pc       = RV;
    m_pend_tgt = 32'h0;
  endtask

  function automatic bit model_fire();
    return m_booted && fetch_ready && !stall;
  endfunction

  task automatic model_advance();
    bit          fire;
    logic [31:0] tgt;
    fire  = model_fire();
    tgt   = (redirect_target / INC) * INC;
    m_mis = m_booted && redirect_valid && ((redirect_target % INC) != 0);
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (fire) begin
      if (redirect_valid)  m_pc = tgt;
      else if (m_pending)  m_pc = m_pend_tgt;
      else                 m_pc = m_pc + INC;
      m_pending = 1'b0;
    end else if (redirect_valid) begin
      m_pending  = 1'b1;
      m_pend_tgt = tgt;
    end
  endtask

  task automatic compare_all();
    bit        ef;
    pc_state_t es;
    ef = model_fire();
    es = !m_booted ? BOOT : (m_pending ? PEND : RUN);
    check("pc_valid",    32'(pc_valid),    32'(m_booted));
    check("pc_out",      pc_out,           m_pc);
    check("pc_plus_inc", pc_plus_inc,      m_pc + INC);
    check("fetch_fire",  32'(fetch_fire),  32'(ef));
    check("kill_fetch",  32'(kill_fetch),  32'(ef && (m_pending || redirect_valid)));
    check("state",       32'(state_dbg),   32'(es));
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
  endtask

  // driver tasks
  task automatic set(input logic s, input logic rdy, input logic rv, input logic [31:0] t);
    stall           = s;
    fetch_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = t;
    #1;
  endtask

  task automatic step();
    if (!rst) model_reset();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (rst) model_advance();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_pc_valid", 32'(pc_valid),   32'h0);
    check("rst_pc_out",   pc_out,          RV);
    check("rst_fire",     32'(fetch_fire), 32'h0);
    check("rst_kill",     32'(kill_fetch), 32'h0);
    check("rst_state",    32'(state_dbg),  32'(BOOT));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // boot then sequential fetch
    step();
    check("boot_pc0", pc_out, 32'h0);
    step(); check("seq_pc4", pc_out, 32'h4);
    step(); check("seq_pc8", pc_out, 32'h8);
    step(); step();
    check("seq_pc10", pc_out, 32'h10);

    // stall hold
    set(1, 1, 0, 32'h0);
    repeat (3) begin
      step();
      check("stall_hold_pc", pc_out, 32'h10);
      check("stall_no_fire", 32'(fetch_fire), 32'h0);
    end
    set(0, 1, 0, 32'h0);
    step();
    check("stall_release_pc", pc_out, 32'h14);
    step(); step(); step();
    check("seq_pc20", pc_out, 32'h20);

    // redirect accepted with the fetch
    set(0, 1, 1, 32'h100);
    check("redir_kill", 32'(kill_fetch), 32'h1);
    step();
    check("redir_pc", pc_out, 32'h100);

    // redirect while memory is busy, latest wins
    set(0, 1, 1, 32'h30); step();
    set(0, 0, 1, 32'h200); step();
    check("busy_hold_a", pc_out, 32'h30);
    set(0, 0, 1, 32'h300); step();
    check("busy_hold_b", pc_out, 32'h30);
    check("busy_state", 32'(state_dbg), 32'(PEND));
    set(0, 0, 0, 32'h0); step();
    check("busy_hold_c", pc_out, 32'h30);
    set(0, 1, 0, 32'h0);
    check("busy_fire", 32'(fetch_fire), 32'h1);
    check("busy_kill", 32'(kill_fetch), 32'h1);
    step();
    check("busy_latest", pc_out, 32'h300);

    // wrap-around
    set(0, 1, 1, 32'hFFFF_FFFC); step();
    check("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
    check("wrap_plus_top", pc_plus_inc, 32'h0);
    set(0, 1, 0, 32'h0); step();
    check("wrap_pc0", pc_out, 32'h0);
    check("wrap_plus4", pc_plus_inc, 32'h4);

    // misaligned target is forced aligned
    set(0, 1, 1, 32'h103); step();
    check("misalign_pc", pc_out, 32'h100);
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_pulse", 32'(misalign_err), 32'h1);
`endif
    set(0, 1, 0, 32'h0); step();
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_clear", 32'(misalign_err), 32'h0);
`endif
    check("misalign_next", pc_out, 32'h104);

    // stall does not block redirect capture
    set(1, 1, 1, 32'h400); step();
    check("stall_capture_hold", pc_out, 32'h104);
    set(0, 1, 0, 32'h0); step();
    check("stall_capture_pc", pc_out, 32'h400);

    // async reset discards a pending redirect
    set(0, 0, 1, 32'h500); step();
    set(0, 0, 0, 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(pc_valid), 32'h0);
    check("midrst_pc", pc_out, RV);
    step();
    rst = 1'b1;
    set(0, 1, 0, 32'h0);
    step(); step();
    check("midrst_after", pc_out, 32'h4);

    // random traffic
    repeat (400) begin
      rst = ($urandom_range(0, 49) != 0);
      set($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0, $urandom());
      step();
    end
    rst = 1'b1;
    set(0, 1, 0, 32'h0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined RISC-V fetch stage. It replaces the plain PC register and adds the following:
- a configurable reset vector and increment;
- a valid/ready fetch handshake toward instruction memory;
- hazard stall;
- branch/jump/trap redirect, with a pending-redirect state so the address held in an outstanding fetch is never disturbed.

It sits between the hazard/branch-resolution logic (EX stage) and the IF-stage memory interface.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. It is XLEN bits wide and must be aligned to INC.
- INC, 4, sequential increment in bytes. The legal values are 2 and 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous and active-low: rst=0 resets immediately; release is sampled on clk.
- stall  in  1  hazard stall; blocks fetch acceptance.
- redirect_valid  in  1  single-cycle request to change the PC.
- redirect_target  in  XLEN  new PC for the redirect.
- fetch_ready  in  1  instruction memory accepts pc_out this cycle.
- pc_valid  out  1  pc_out is a valid fetch request.
- pc_out  out  XLEN  current fetch address.
- pc_plus_inc  out  XLEN  pc_out + INC, modulo 2^XLEN, forwarded for link-register writes.
- fetch_fire  out  1  equals pc_valid & fetch_ready & ~stall; a fetch is accepted this cycle.
- kill_fetch  out  1  qualifies fetch_fire: the instruction accepted this cycle is stale and must be discarded downstream.

Behaviour:
- State machine. States are BOOT, RUN and PEND.
- Reset (rst=0):
  - state=BOOT, pc_out=RESET_VECTOR, pending target=0;
  - pc_valid=0, fetch_fire=0, kill_fetch=0.
- BOOT:
  - pc_valid=0;
  - on the first clk edge with rst=1, go to RUN;
  - redirect_valid in BOOT is ignored.
- RUN:
  - pc_valid=1.
  - If redirect_valid, the target depends on the handshake:
    - if pc_valid & fetch_ready & ~stall (handshake completes this cycle): pc_out <= redirect_target; kill_fetch=1 this cycle; stay in RUN;
    - otherwise: capture redirect_target into the pending register and go to PEND; pc_out is unchanged.
  - Else if fetch_fire: pc_out <= pc_out + INC.
  - Else: hold pc_out.
- PEND:
  - pc_valid=1 and pc_out holds the old address. This keeps the request stable while it is unaccepted.
  - A new redirect_valid overwrites the pending target; the latest redirect wins.
  - On fetch_fire:
    - kill_fetch=1;
    - pc_out <= pending target, or redirect_target if a redirect arrives in the same cycle;
    - go to RUN.
- Stability rule: while pc_valid=1 and fetch_fire=0, pc_out must not change. The only exception is reset.
- Simultaneous events:
  - redirect beats sequential increment;
  - stall only blocks acceptance and never blocks capture of a redirect.
- Wrap-around: PC 2^XLEN−INC increments to 0; no flag is raised.
- Alignment: the low log2(INC) bits of redirect_target are forced to 0 before use.
- Reset mid-operation: any pending redirect is discarded and state returns to BOOT asynchronously.
- Latency: redirect to new pc_out is one cycle when accepted, or the cycle after the stale fetch fires.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - adds output misalign_err (1 bit, registered, reset 0);
  - misalign_err is asserted for exactly one cycle after a captured redirect_target has any of bits [log2(INC)-1:0] nonzero;
  - the forced alignment is still applied.
- Undefined: the port is absent and misalignment is silently masked.

Decomposition:
- Package pc_pkg holds:
  - state enum pc_state_t {BOOT, RUN, PEND};
  - INC_RV32I=4 and INC_RVC=2 constants;
  - function align_pc(addr, inc).
- One natural sub-module is pc_next_sel, a combinational next-PC/priority mux. The state register, PC register and pending register stay in pc_unit.

Test Plan:
- Reset and boot: rst=0 then released, fetch_ready=1. Cycle 0 gives pc_valid=0 with pc_out=0. The next cycles give pc_out=0, 4, 8 with fetch_fire=1 each cycle.
- Stall hold: at pc_out=0x10, stall=1 for 3 cycles. pc_out stays 0x10 and fetch_fire=0 throughout; it advances to 0x14 on the first cycle after stall drops.
- Redirect with ready: at pc_out=0x20, fetch_ready=1, redirect_target=0x100. The same cycle gives kill_fetch=1 and the next cycle gives pc_out=0x100.
- Redirect while busy: at pc_out=0x30, fetch_ready=0, redirect 0x200, then redirect 0x300. The bench must check three things:
  - pc_out stays 0x30 while fetch_ready=0;
  - when fetch_ready rises, fetch_fire=1 and kill_fetch=1;
  - the next cycle gives pc_out=0x300.
- Wrap: redirect to 0xFFFF_FFFC, then fetch. pc_out becomes 0x0 and pc_plus_inc becomes 0x4.
- Misaligned target (with PC_MISALIGN_CHECK_EN): redirect to 0x103. pc_out=0x100 and misalign_err pulses for 1 cycle. Without the macro, pc_out=0x100 and there is no error port.
